des_core_scheduler: RTL
=======================

Name: des_core_scheduler

Overview:
- Round-robin scheduler that shares one iterative DES encryption core among NUM_REQ requesters.
- Accepts a 64-bit message from the winning requester and latches the shared 768-bit round-key bus at grant.
- Pulses the core's start, waits for its done, and returns the result tagged with the requester ID over a valid/ready response channel.
- Sits between the request-generating logic and a single des_encryption-class core (iterative or unrolled; any core with a start/done interface).

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, response ID width; must equal ceil(log2(NUM_REQ)).
- TIMEOUT, 64, watchdog limit in cycles; used only with DES_SCHED_TIMEOUT_EN.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_msg  in  NUM_REQ*64  messages; requester i uses bits [64*i+63:64*i].
- round_keys_in  in  768  shared round keys, sampled at grant.
- core_start  out  1  one-cycle start pulse to the core.
- core_message  out  64  latched message to the core.
- core_round_keys  out  768  latched keys to the core.
- core_done  in  1  core completion.
- core_result  in  64  core ciphertext.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  ID_W  requester index of the response.
- rsp_data  out  64  ciphertext.
- rsp_err  out  1  timeout flag; tied 0 without the macro.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst=1 at posedge) from any state, including mid-operation:
  - state=IDLE, rr pointer=0.
  - All outputs 0; latched message, keys, ID and result cleared.
  - A core run in progress is abandoned; any later core_done is ignored.
- FSM states: IDLE, START, WAIT, RESP.
- IDLE:
  - If any req_valid is set, grant the first set bit searching from ptr upward with wrap (ptr, ptr+1, ..., NUM_REQ-1, 0, ...).
  - req_ready[g]=1 combinationally in that same cycle; the handshake completes there.
  - On that edge: latch req_msg[g], round_keys_in and g; ptr <= (g+1) mod NUM_REQ; go to START.
  - With no req_valid: stay in IDLE, ptr unchanged.
- START: core_start=1 for exactly one cycle; go to WAIT.
- WAIT:
  - On core_done=1: latch core_result into rsp_data and go to RESP.
  - core_done is ignored in IDLE, START and RESP.
- RESP:
  - rsp_valid=1; rsp_id and rsp_data stay stable until rsp_ready=1.
  - On the rsp_ready edge go to IDLE; rsp_valid drops the next cycle.
  - No new grant is made in the cycle rsp_ready is seen.
- Latency: core_start rises 1 cycle after the accept; rsp_valid rises 1 cycle after core_done.
- Per-transaction overhead beyond the core's latency: 3 cycles plus response back-pressure.
- req_ready is asserted only in IDLE. A requester that holds req_valid keeps it until accepted; its message must not change while waiting.
- core_message and core_round_keys hold their latched values from START until the next grant.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0,...

Optional Feature:
- DES_SCHED_TIMEOUT_EN defined:
  - A cycle counter clears on entry to WAIT.
  - If the counter reaches TIMEOUT without core_done, go to RESP with rsp_err=1 and rsp_data=0.
  - rsp_err is cleared on every normal completion.
- Not defined: no counter; WAIT waits indefinitely; rsp_err is constant 0.

Test Plan:
- Single request: rst pulse; req_valid=4'b0100, req_msg[2]=64'h0123456789ABCDEF; model core asserts done 16 cycles after start with result 64'h85E813540F0AB405 -> req_ready=4'b0100 for 1 cycle; core_start exactly 1 cycle later; rsp_valid 1 cycle after done with rsp_id=2, rsp_data=64'h85E813540F0AB405.
- Fairness: all 4 req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0; ptr wraps to 0.
- Back-pressure: rsp_ready=0 for 10 cycles in RESP -> rsp_valid/id/data stable; no req_ready asserted; no core_start issued.
- Reset mid-run: assert rst in WAIT, then core_done=1 the following cycle -> all outputs 0, state IDLE, no rsp_valid.
- Spurious done: core_done=1 in IDLE and RESP -> no state change, rsp_data unchanged.
- With DES_SCHED_TIMEOUT_EN and TIMEOUT=8: core never asserts done -> rsp_valid rises with rsp_err=1, rsp_data=0 once the counter reaches 8 in WAIT.

Source files
------------

// File: rtl/des_core_scheduler.sv
// des_core_scheduler: round-robin arbiter that shares one start/done DES core between
// NUM_REQ requesters. The winner's 64-bit message and the shared 768-bit round-key bus are
// latched at grant. The core is started with a one-cycle pulse. The ciphertext goes back on a
// valid/ready response channel, tagged with the requester index.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   req_valid/ready   per-requester handshake; req_ready is one-hot or zero, only in idle
//   req_msg           packed messages, requester i at [64*i+63:64*i]
//   round_keys_in     shared round keys, sampled at grant
//   core_start        one-cycle start pulse to the core
//   core_message      latched message, held until the next grant
//   core_round_keys   latched round keys, held until the next grant
//   core_done/result  core completion and ciphertext
//   rsp_valid/ready   response handshake; rsp_id/rsp_data/rsp_err are stable while stalled
//   busy              high whenever the scheduler is not idle
//
// Optional build macro DES_SCHED_TIMEOUT_EN adds a watchdog on the core. If done does not
// arrive within TIMEOUT cycles, the scheduler responds with rsp_err=1 and rsp_data=0. Without
// the macro, rsp_err is tied low and the scheduler waits for done indefinitely.
module des_core_scheduler #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*64-1:0]  req_msg,
    input  logic [767:0]           round_keys_in,
    output logic                   core_start,
    output logic [63:0]            core_message,
    output logic [767:0]           core_round_keys,
    input  logic                   core_done,
    input  logic [63:0]            core_result,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [63:0]            rsp_data,
    output logic                   rsp_err,
    output logic                   busy
);

    if (ID_W != $clog2(NUM_REQ) || NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT == 0) begin : g_bad_params
        $error("des_core_scheduler: inconsistent NUM_REQ/ID_W/TIMEOUT");
    end

    typedef enum logic [1:0] {StIdle, StStart, StWait, StResp} state_e;

    state_e          state_q;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] id_q;
    logic [63:0]     msg_q;
    logic [767:0]    keys_q;
    logic [63:0]     data_q;
    logic            core_start_q;
    logic            rsp_valid_q;

`ifdef DES_SCHED_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    logic [CntW-1:0] cnt_q;
    logic            err_q;
`endif

    // Arbitration: the lowest valid index at or above ptr wins. If there is none, the search
    // wraps, so the lowest valid index overall wins.
    logic            gnt_found;
    logic            up_found;
    logic [ID_W-1:0] up_idx;
    logic [ID_W-1:0] any_idx;
    logic [ID_W-1:0] gnt_idx;
    logic [63:0]     gnt_msg;

    always_comb begin
        gnt_found = 1'b0;
        up_found  = 1'b0;
        up_idx    = '0;
        any_idx   = '0;
        // Descending scan so the last hit is the lowest index.
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                gnt_found = 1'b1;
                any_idx   = ID_W'(i);
                if (i >= int'(ptr_q)) begin
                    up_found = 1'b1;
                    up_idx   = ID_W'(i);
                end
            end
        end
        gnt_idx = up_found ? up_idx : any_idx;
        gnt_msg = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (ID_W'(i) == gnt_idx) begin
                gnt_msg = req_msg[i*64 +: 64];
            end
        end
    end

    assign ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

    // The accept handshake completes combinationally in the idle cycle.
    always_comb begin
        req_ready = '0;
        if (!rst && state_q == StIdle && gnt_found) begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                req_ready[i] = (ID_W'(i) == gnt_idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            id_q         <= '0;
            msg_q        <= '0;
            keys_q       <= '0;
            data_q       <= '0;
            core_start_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
`ifdef DES_SCHED_TIMEOUT_EN
            cnt_q        <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            core_start_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (gnt_found) begin
                        msg_q        <= gnt_msg;
                        keys_q       <= round_keys_in;
                        id_q         <= gnt_idx;
                        ptr_q        <= ptr_d;
                        core_start_q <= 1'b1;
                        state_q      <= StStart;
                    end
                end
                StStart: begin
                    state_q <= StWait;
`ifdef DES_SCHED_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
                StWait: begin
                    if (core_done) begin
                        data_q      <= core_result;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StResp;
`ifdef DES_SCHED_TIMEOUT_EN
                        err_q       <= 1'b0;
                    end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                        // The TIMEOUT-th cycle in wait has gone by without done.
                        data_q      <= '0;
                        err_q       <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StResp;
                    end else begin
                        cnt_q       <= cnt_q + 1'b1;
`endif
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign core_start      = core_start_q;
    assign core_message    = msg_q;
    assign core_round_keys = keys_q;
    assign rsp_valid       = rsp_valid_q;
    assign rsp_id          = id_q;
    assign rsp_data        = data_q;
    assign busy            = (state_q != StIdle);
`ifdef DES_SCHED_TIMEOUT_EN
    assign rsp_err         = err_q;
`else
    assign rsp_err         = 1'b0;
`endif

endmodule
